// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store controller between the multicycle core and a word-wide data
//   memory. Takes one byte/halfword/word request at a byte address. It then
//   issues word-addressed accesses. Loads return the selected lane, sign- or
//   zero-extended. Sub-word stores use read-modify-write because the memory
//   only writes whole words.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_req             request strobe, sampled only while o_ready=1
//   i_we              1 = store, 0 = load
//   i_size            00 byte, 01 halfword, 10 word, 11 illegal
//   i_unsigned        load extension: 1 = zero-extend, 0 = sign-extend
//   i_addr            byte address (ADDR_WIDTH+2 bits)
//   i_wdata           store data; the lane is taken from the low bits
//   o_ready           unit idle, a request can be accepted this cycle
//   o_done, o_err     one-cycle completion pulse; error qualifier
//   o_rdata           last load result, held until the next load completes
//   o_mem_wenable     registered memory write enable (high only in WRITE)
//   o_mem_address     registered memory word address
//   o_mem_wdata       registered memory write word
//   i_mem_rdata       memory read word, combinational from o_mem_address
module mem_access_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [ADDR_WIDTH+1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_ready,
  output logic                  o_done,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_mem_wenable,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t state, state_nxt;

  logic        we_p0;
  logic [1:0]  size_p0;
  logic        uns_p0;
  logic [1:0]  off_p0;
  logic [31:0] wdata_p0;
  logic        err_p0;

  logic        req_err;
  logic        word_store;

  // Extract the addressed lane of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of a memory word with the low bits of wdata.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: r[{off, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign req_err = (i_size == 2'b11) ||
                   (i_size == 2'b01 && i_addr[0]) ||
                   (i_size == 2'b10 && i_addr[1:0] != 2'b00);
  assign word_store = i_we && (i_size == 2'b10);

  assign o_ready = (state == IDLE);
  assign o_done  = (state == DONE);
  assign o_err   = (state == DONE) && err_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_req) begin
          if (req_err)         state_nxt = DONE;
          else if (word_store) state_nxt = WRITE;
          else                 state_nxt = READ;
        end
      end
      READ:    state_nxt = we_p0 ? WRITE : DONE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: request capture at accept; memory word sampled in READ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_p0         <= 1'b0;
      size_p0       <= 2'b00;
      uns_p0        <= 1'b0;
      off_p0        <= 2'b00;
      wdata_p0      <= '0;
      err_p0        <= 1'b0;
      o_rdata       <= '0;
      o_mem_wenable <= 1'b0;
      o_mem_address <= '0;
      o_mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req) begin
            we_p0         <= i_we;
            size_p0       <= i_size;
            uns_p0        <= i_unsigned;
            off_p0        <= i_addr[1:0];
            wdata_p0      <= i_wdata;
            err_p0        <= req_err;
            o_mem_address <= i_addr[ADDR_WIDTH+1:2];
            // Aligned word stores skip the read and go straight to WRITE.
            if (!req_err && word_store) begin
              o_mem_wdata   <= i_wdata;
              o_mem_wenable <= 1'b1;
            end
          end
        end
        READ: begin
          if (we_p0) begin
            o_mem_wdata   <= store_merge(i_mem_rdata, wdata_p0, size_p0, off_p0);
            o_mem_wenable <= 1'b1;
          end else begin
            o_rdata <= load_extend(i_mem_rdata, size_p0, off_p0, uns_p0);
          end
        end
        WRITE:   o_mem_wenable <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed bench for mem_access_unit with a behavioural word memory.
//   It checks results against hand-computed values.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_we, i_unsigned;
  logic [1:0]  i_size;
  logic [9:0]  i_addr;
  logic [31:0] i_wdata;
  logic        o_ready, o_done, o_err, o_mem_wenable;
  logic [31:0] o_rdata, o_mem_wdata, i_mem_rdata;
  logic [7:0]  o_mem_address;

  logic [31:0] mem [256];
  int          wen_cnt = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_we(i_we), .i_size(i_size), .i_unsigned(i_unsigned),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .o_ready(o_ready), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
    .o_mem_wenable(o_mem_wenable), .o_mem_address(o_mem_address),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  assign i_mem_rdata = mem[o_mem_address];

  always @(posedge clk) begin
    if (o_mem_wenable) begin
      mem[o_mem_address] <= o_mem_wdata;
      wen_cnt <= wen_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE (called at posedge+1), wait for o_done and
  // check latency, error flag and number of write-enable cycles.
  task automatic run(input string tag, input logic we, input logic [1:0] size,
                     input logic uns, input logic [9:0] addr, input logic [31:0] wdata,
                     input int exp_lat, input logic exp_err, input int exp_wens);
    int lat;
    int w0;
    logic err;
    w0 = wen_cnt;
    i_we = we; i_size = size; i_unsigned = uns; i_addr = addr; i_wdata = wdata;
    i_req = 1'b1;
    @(posedge clk); #1;
    i_req = 1'b0;
    lat = 1;
    while (!o_done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    err = o_err;
    @(posedge clk); #1;
    check({tag, " lat"}, lat, exp_lat);
    check({tag, " err"}, 32'(err), 32'(exp_err));
    check({tag, " wen"}, wen_cnt - w0, exp_wens);
    check({tag, " ready"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    int lat1;
    int gap;
    int w0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    i_req = 1'b0; i_we = 1'b0; i_size = 2'b00; i_unsigned = 1'b0;
    i_addr = '0; i_wdata = '0;
    #12;
    check("rst ready", 32'(o_ready), 32'd1);
    check("rst done", 32'(o_done), 32'd0);
    check("rst err", 32'(o_err), 32'd0);
    check("rst rdata", o_rdata, 32'h0);
    check("rst wen", 32'(o_mem_wenable), 32'd0);
    check("rst addr", 32'(o_mem_address), 32'd0);
    check("rst wdata", o_mem_wdata, 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store / word load
    run("sw4", 1'b1, 2'b10, 1'b0, 10'h004, 32'h11223344, 2, 1'b0, 1);
    check("sw4 mem", mem[1], 32'h11223344);
    run("lw4", 1'b0, 2'b10, 1'b0, 10'h004, 32'h0, 2, 1'b0, 0);
    check("lw4 rdata", o_rdata, 32'h11223344);

    // Byte store with junk in the upper wdata bits, then byte loads
    run("sb6", 1'b1, 2'b00, 1'b0, 10'h006, 32'h123456AB, 3, 1'b0, 1);
    check("sb6 mem", mem[1], 32'h11AB3344);
    check("sb6 rdata kept", o_rdata, 32'h11223344);
    run("lb6", 1'b0, 2'b00, 1'b0, 10'h006, 32'h0, 2, 1'b0, 0);
    check("lb6 rdata", o_rdata, 32'hFFFFFFAB);
    run("lbu6", 1'b0, 2'b00, 1'b1, 10'h006, 32'h0, 2, 1'b0, 0);
    check("lbu6 rdata", o_rdata, 32'h000000AB);

    // Halfword store onto all-ones, then halfword loads
    run("sw8", 1'b1, 2'b10, 1'b0, 10'h008, 32'hFFFFFFFF, 2, 1'b0, 1);
    run("sh8", 1'b1, 2'b01, 1'b0, 10'h008, 32'hCDEF8001, 3, 1'b0, 1);
    check("sh8 mem", mem[2], 32'hFFFF8001);
    run("lh8", 1'b0, 2'b01, 1'b0, 10'h008, 32'h0, 2, 1'b0, 0);
    check("lh8 rdata", o_rdata, 32'hFFFF8001);
    run("lhA", 1'b0, 2'b01, 1'b0, 10'h00A, 32'h0, 2, 1'b0, 0);
    check("lhA rdata", o_rdata, 32'hFFFFFFFF);
    run("lhuA", 1'b0, 2'b01, 1'b1, 10'h00A, 32'h0, 2, 1'b0, 0);
    check("lhuA rdata", o_rdata, 32'h0000FFFF);

    // Misaligned / illegal requests
    run("lw5 err", 1'b0, 2'b10, 1'b0, 10'h005, 32'h0, 1, 1'b1, 0);
    check("lw5 rdata kept", o_rdata, 32'h0000FFFF);
    run("lh3 err", 1'b0, 2'b01, 1'b0, 10'h003, 32'h0, 1, 1'b1, 0);
    check("lh3 rdata kept", o_rdata, 32'h0000FFFF);
    run("sz11 err", 1'b1, 2'b11, 1'b0, 10'h008, 32'h0, 1, 1'b1, 0);
    check("sz11 mem kept", mem[2], 32'hFFFF8001);
    run("sw5 err", 1'b1, 2'b10, 1'b0, 10'h005, 32'hDEADBEEF, 1, 1'b1, 0);
    check("sw5 mem kept", mem[1], 32'h11AB3344);

    // Request held high: byte store then a load queued behind it
    i_we = 1'b1; i_size = 2'b00; i_unsigned = 1'b0; i_addr = 10'h00C; i_wdata = 32'h00000055;
    i_req = 1'b1;
    @(posedge clk); #1;
    i_we = 1'b0; i_unsigned = 1'b1;
    lat1 = 1;
    while (!o_done && lat1 < 10) begin
      @(posedge clk); #1;
      lat1++;
    end
    check("held sb lat", lat1, 3);
    check("held ready at done", 32'(o_ready), 32'd0);
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
      if (gap == 1) check("held ready after done", 32'(o_ready), 32'd1);
    end while (!o_done && gap < 10);
    i_req = 1'b0;
    check("held gap", gap, 3);
    check("held lbu rdata", o_rdata, 32'h00000055);
    check("held mem", mem[3], 32'h00000055);
    @(posedge clk); #1;

    // Reset during READ of a byte store
    w0 = wen_cnt;
    i_we = 1'b1; i_size = 2'b00; i_unsigned = 1'b0; i_addr = 10'h004; i_wdata = 32'h000000EE;
    i_req = 1'b1;
    @(posedge clk); #1;
    i_req = 1'b0;
    rst_n = 1'b0;
    #2;
    check("mid rst ready", 32'(o_ready), 32'd1);
    check("mid rst wen", 32'(o_mem_wenable), 32'd0);
    check("mid rst rdata", o_rdata, 32'h0);
    check("mid rst addr", 32'(o_mem_address), 32'd0);
    check("mid rst wdata", o_mem_wdata, 32'h0);
    check("mid rst done", 32'(o_done), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("mid rst no write", wen_cnt - w0, 0);
    check("mid rst mem kept", mem[1], 32'h11AB3344);
    check("mid rst ready after", 32'(o_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
